// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage driving a 1-cycle synchronous instruction memory.
// Optional build macro PC_FETCH_PERF_EN adds saturating fetch/redirect performance counters.
module pc_fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int INSTR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         NextInstrSel,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               stall,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               imem_en,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               instr_valid,
    output logic               redirect,
    output logic               halted,
`ifdef PC_FETCH_PERF_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_redirects,
`endif
    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    logic [ADDR_W-1:0] pc_q;

    // stall is decode back-pressure: while high the fetch stage holds every
    // register and the memory output (imem_en=0); the select is re-presented later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc_q        <= RESET_PC;
            pc_out      <= '0;
            instr_valid <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (!stall) begin
                        pc_out <= pc_q;
                        case (NextInstrSel)
                            2'b00: begin
                                pc_q        <= pc_q + PC_ONE;
                                instr_valid <= 1'b1;
                            end
                            2'b01: begin
                                pc_q        <= branch_target;
                                instr_valid <= 1'b0;
                            end
                            2'b10: begin
                                pc_q        <= jump_target;
                                instr_valid <= 1'b0;
                            end
                            default: begin
                                state       <= HALT;
                                instr_valid <= 1'b0;
                            end
                        endcase
                    end
                end
                HALT: begin
                    instr_valid <= 1'b0;
                end
                default: begin
                    state       <= BOOT;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign imem_en   = rst_n && ((state == BOOT) || ((state == RUN) && !stall));
    assign instr_out = imem_rdata;
    assign redirect  = (state == RUN) && !stall &&
                       ((NextInstrSel == 2'b01) || (NextInstrSel == 2'b10));
    assign halted    = (state == HALT);
    assign state_dbg = state;

`ifdef PC_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else begin
            if (instr_valid && !stall && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect && (perf_redirects != 32'hFFFF_FFFF)) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: cycle-by-cycle vector table plus hand sequences for
// async reset, address wrap (16-bit and 4-bit instances) and back-to-back redirects.
module tb_pc_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic [1:0]  sel;
    logic [15:0] bt;
    logic [15:0] jt;
    logic        stall;

    logic [15:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic [31:0] instr_out;
    logic [15:0] pc_out;
    logic        instr_valid;
    logic        redirect;
    logic        halted;
    logic [1:0]  state_dbg;
`ifdef PC_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;
`endif

    logic [3:0]  imem_addr4;
    logic        imem_en4;
    logic [31:0] imem_rdata4;
    logic [31:0] instr_out4;
    logic [3:0]  pc_out4;
    logic        instr_valid4;
    logic        redirect4;
    logic        halted4;
    logic [1:0]  state_dbg4;
`ifdef PC_FETCH_PERF_EN
    logic [31:0] perf_fetched4;
    logic [31:0] perf_redirects4;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    pc_fetch_unit #(.ADDR_W(16), .INSTR_W(32), .RESET_PC(16'h0)) u_dut (
        .clk(clk), .rst_n(rst_n), .NextInstrSel(sel),
        .branch_target(bt), .jump_target(jt), .stall(stall),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid),
        .redirect(redirect), .halted(halted),
`ifdef PC_FETCH_PERF_EN
        .perf_fetched(perf_fetched), .perf_redirects(perf_redirects),
`endif
        .state_dbg(state_dbg)
    );

    pc_fetch_unit #(.ADDR_W(4), .INSTR_W(32), .RESET_PC(4'h0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .NextInstrSel(sel),
        .branch_target(bt[3:0]), .jump_target(jt[3:0]), .stall(stall),
        .imem_addr(imem_addr4), .imem_en(imem_en4), .imem_rdata(imem_rdata4),
        .instr_out(instr_out4), .pc_out(pc_out4), .instr_valid(instr_valid4),
        .redirect(redirect4), .halted(halted4),
`ifdef PC_FETCH_PERF_EN
        .perf_fetched(perf_fetched4), .perf_redirects(perf_redirects4),
`endif
        .state_dbg(state_dbg4)
    );

    // clock / memory models: data = address + 0x100, held while enable is low
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (imem_en) imem_rdata <= {16'h0, imem_addr} + 32'h100;
        if (imem_en4) imem_rdata4 <= {28'h0, imem_addr4} + 32'h100;
    end

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] bt;
        logic [15:0] jt;
        logic        st;
        logic [15:0] addr;
        logic        en;
        logic        redir;
        logic        valid;
        logic [15:0] pc;
        logic        halt;
    } vec_t;

    vec_t vecs[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step(input logic [1:0] s, input logic [15:0] b, input logic [15:0] j,
                        input logic st);
        @(negedge clk);
        rst_n = 1'b1;
        sel   = s;
        bt    = b;
        jt    = j;
        stall = st;
        #1;
    endtask

    task automatic check_cycle(input string tag, input logic [15:0] a, input logic en,
                               input logic r, input logic v, input logic [15:0] p,
                               input logic h);
        chk({tag, ".imem_addr"}, {16'h0, imem_addr}, {16'h0, a});
        chk({tag, ".imem_en"}, {31'h0, imem_en}, {31'h0, en});
        chk({tag, ".redirect"}, {31'h0, redirect}, {31'h0, r});
        chk({tag, ".instr_valid"}, {31'h0, instr_valid}, {31'h0, v});
        chk({tag, ".pc_out"}, {16'h0, pc_out}, {16'h0, p});
        chk({tag, ".halted"}, {31'h0, halted}, {31'h0, h});
        if (v) chk({tag, ".instr_out"}, instr_out, {16'h0, p} + 32'h100);
    endtask

    task automatic check4(input string tag, input logic [3:0] a, input logic v,
                          input logic [3:0] p);
        chk({tag, ".addr4"}, {28'h0, imem_addr4}, {28'h0, a});
        chk({tag, ".valid4"}, {31'h0, instr_valid4}, {31'h0, v});
        chk({tag, ".pc4"}, {28'h0, pc_out4}, {28'h0, p});
        if (v) chk({tag, ".instr4"}, instr_out4, {28'h0, p} + 32'h100);
    endtask

    initial begin
        //            sel    bt        jt        st    addr      en    rd    vld   pc        halt
        vecs[0]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[2]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[3]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0};
        vecs[4]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0003, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b0};
        vecs[5]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b1, 16'h0003, 1'b0};
        vecs[6]  = '{2'b01, 16'h0040, 16'h0000, 1'b0, 16'h0005, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b0};
        vecs[7]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0040, 1'b1, 1'b0, 1'b0, 16'h0005, 1'b0};
        vecs[8]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0041, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b0};
        vecs[9]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0042, 1'b1, 1'b0, 1'b1, 16'h0041, 1'b0};
        vecs[10] = '{2'b10, 16'h0000, 16'h0200, 1'b1, 16'h0043, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b0};
        vecs[11] = '{2'b10, 16'h0000, 16'h0200, 1'b1, 16'h0043, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b0};
        vecs[12] = '{2'b10, 16'h0000, 16'h0200, 1'b1, 16'h0043, 1'b0, 1'b0, 1'b1, 16'h0042, 1'b0};
        vecs[13] = '{2'b10, 16'h0000, 16'h0200, 1'b0, 16'h0043, 1'b1, 1'b1, 1'b1, 16'h0042, 1'b0};
        vecs[14] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0200, 1'b1, 1'b0, 1'b0, 16'h0043, 1'b0};
        vecs[15] = '{2'b00, 16'h0000, 16'h0000, 1'b0, 16'h0201, 1'b1, 1'b0, 1'b1, 16'h0200, 1'b0};
        vecs[16] = '{2'b11, 16'h0000, 16'h0000, 1'b0, 16'h0202, 1'b1, 1'b0, 1'b1, 16'h0201, 1'b0};
        vecs[17] = '{2'b01, 16'h0007, 16'h0009, 1'b0, 16'h0202, 1'b0, 1'b0, 1'b0, 16'h0202, 1'b1};
        vecs[18] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 16'h0202, 1'b0, 1'b0, 1'b0, 16'h0202, 1'b1};

        rst_n = 1'b0;
        sel   = 2'b00;
        bt    = 16'h0;
        jt    = 16'h0;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cycle("reset", 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].sel, vecs[i].bt, vecs[i].jt, vecs[i].st);
            check_cycle($sformatf("vec%0d", i), vecs[i].addr, vecs[i].en, vecs[i].redir,
                        vecs[i].valid, vecs[i].pc, vecs[i].halt);
        end

`ifdef PC_FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, 32'd10);
        chk("perf_redirects", perf_redirects, 32'd2);
`endif

        // async reset pulse while halted, away from any clock edge
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_cycle("midrst", 16'h0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);

        // restart from RESET_PC, then jump near the top of both address spaces
        step(2'b00, 16'h0, 16'h0, 1'b0);
        check_cycle("b0", 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(2'b10, 16'h0, 16'hFFFE, 1'b0);
        check_cycle("b1", 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
        step(2'b00, 16'h0, 16'h0, 1'b0);
        check_cycle("b2", 16'hFFFE, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        check4("b2", 4'hE, 1'b0, 4'h0);
        step(2'b00, 16'h0, 16'h0, 1'b0);
        check_cycle("b3", 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        check4("b3", 4'hF, 1'b1, 4'hE);
        step(2'b00, 16'h0, 16'h0, 1'b0);
        check_cycle("b4", 16'h0000, 1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        check4("b4", 4'h0, 1'b1, 4'hF);
        step(2'b00, 16'h0, 16'h0, 1'b0);
        check_cycle("b5", 16'h0001, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
        check4("b5", 4'h1, 1'b1, 4'h0);

        // back-to-back branch then jump: each squashes its following slot
        step(2'b01, 16'h0080, 16'h0, 1'b0);
        check_cycle("b6", 16'h0002, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0);
        step(2'b10, 16'h0, 16'h0090, 1'b0);
        check_cycle("b7", 16'h0080, 1'b1, 1'b1, 1'b0, 16'h0002, 1'b0);
        step(2'b00, 16'h0, 16'h0, 1'b0);
        check_cycle("b8", 16'h0090, 1'b1, 1'b0, 1'b0, 16'h0080, 1'b0);
        step(2'b00, 16'h0, 16'h0, 1'b0);
        check_cycle("b9", 16'h0091, 1'b1, 1'b0, 1'b1, 16'h0090, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
